// File: rtl/flash_test_pkg.sv
// Shared state encoding and default parameter values for the flash self-test sequencer.
package flash_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERASE = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [23:0] DEF_BASE_ADDR = 24'h1a0000;
  localparam logic [7:0]  DEF_LEN       = 8'd16;
  localparam logic [7:0]  DEF_SEED      = 8'h00;
  localparam logic [27:0] DEF_TIMEOUT   = 28'hFFFFFFF;

endpackage

// File: rtl/flash_wdog.sv
// Watchdog for one flash operation: counts enabled cycles from the last clear
// and flags terminal count on the cycle that completes TIMEOUT cycles.
module flash_wdog
  import flash_test_pkg::*;
#(
  parameter logic [27:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [27:0] cnt;

  // tc is raised during the TIMEOUT-th enabled cycle so the caller can leave on that edge
  assign tc = en && ((cnt + 28'd1) >= TIMEOUT);

  // Cycle counter; clear has priority, counting stops once terminal count is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 28'd1;
    end
  end

endmodule

// File: rtl/flash_test_seq.sv
// Flash self-test sequencer: erases one sector, writes a counting pattern,
// reads it back and reports mismatches, missing bytes and watchdog aborts.
module flash_test_seq
  import flash_test_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [7:0]  LEN       = DEF_LEN,
  parameter logic [7:0]  SEED      = DEF_SEED,
  parameter logic [27:0] TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  err_cnt,
  output logic [23:0] first_err_addr,
  output logic        flash_sector_erase,
  output logic        flash_write,
  output logic        flash_read,
  input  logic        flash_sector_erase_ack,
  input  logic        flash_write_ack,
  input  logic        flash_read_ack,
  output logic [23:0] flash_addr,
  output logic [7:0]  flash_size,
  input  logic        flash_write_data_req,
  output logic [7:0]  flash_write_data_in,
  input  logic        flash_read_data_valid,
  input  logic [7:0]  flash_read_data_out
);

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

  state_t     state;
  logic [7:0] wr_idx;
  logic [7:0] rd_idx;

  logic       erase_ack_ok;
  logic       write_ack_ok;
  logic       read_ack_ok;
  logic       leave;
  logic       wd_en;
  logic       wd_clr;
  logic       wd_tc;
  logic       wd_fire;
  logic       rd_take;
  logic       rd_bad;
  logic [8:0] rd_after;
  logic [8:0] miss;
  logic [7:0] err_after_cmp;
  logic [7:0] err_after_ack;

  assign flash_addr          = BASE_ADDR;
  assign flash_size          = LEN;
  assign flash_write_data_in = SEED + wr_idx;

  // Acks only count in the state that issued the matching request
  assign erase_ack_ok = (state == ST_ERASE) && flash_sector_erase_ack;
  assign write_ack_ok = (state == ST_WRITE) && flash_write_ack;
  assign read_ack_ok  = (state == ST_READ)  && flash_read_ack;

  assign wd_en   = (state == ST_ERASE) || (state == ST_WRITE) || (state == ST_READ);
  assign wd_fire = wd_tc && !(erase_ack_ok || write_ack_ok || read_ack_ok);
  assign leave   = erase_ack_ok || write_ack_ok || read_ack_ok || wd_tc;
  // Clearing on every exit means each operation state starts with a fresh count
  assign wd_clr  = (state == ST_IDLE) || leave;

  // Read-back scoring; a valid in the ack cycle is scored before missing bytes are added
  assign rd_take       = (state == ST_READ) && flash_read_data_valid && (rd_idx < LEN);
  assign rd_bad        = rd_take && (flash_read_data_out != (SEED + rd_idx));
  assign rd_after      = {1'b0, rd_idx} + {8'd0, rd_take};
  assign miss          = (rd_after < {1'b0, LEN}) ? ({1'b0, LEN} - rd_after) : 9'd0;
  assign err_after_cmp = rd_bad ? sat_add8(err_cnt, 9'd1) : err_cnt;
  assign err_after_ack = sat_add8(err_after_cmp, miss);

  flash_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .tc    (wd_tc)
  );

  // Sequencer FSM with registered requests, status and result outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      timeout            <= 1'b0;
      err_cnt            <= '0;
      first_err_addr     <= '0;
      flash_sector_erase <= 1'b0;
      flash_write        <= 1'b0;
      flash_read         <= 1'b0;
      wr_idx             <= '0;
      rd_idx             <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_ERASE;
            busy           <= 1'b1;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            wr_idx         <= '0;
            rd_idx         <= '0;
          end
        end
        ST_ERASE: begin
          // Request rises one cycle after entry and falls on the exit edge
          flash_sector_erase <= !leave;
          if (erase_ack_ok) state <= ST_WRITE;
        end
        ST_WRITE: begin
          flash_write <= !leave;
          if (flash_write_data_req && (wr_idx < (LEN - 8'd1))) wr_idx <= wr_idx + 8'd1;
          if (write_ack_ok) state <= ST_READ;
        end
        ST_READ: begin
          flash_read <= !leave;
          if (rd_take) rd_idx <= rd_idx + 8'd1;
          if (rd_bad && (err_cnt == 8'd0)) first_err_addr <= BASE_ADDR + {16'd0, rd_idx};
          err_cnt <= read_ack_ok ? err_after_ack : err_after_cmp;
          if (read_ack_ok) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_after_ack == 8'd0);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      // Watchdog abort overrides whatever the state branch decided
      if (wd_fire) begin
        state   <= ST_DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        pass    <= 1'b0;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flash_test_seq.sv
// Bench for flash_test_seq: a behavioural flash controller driven from tasks,
// with expected run results queued at start and compared at done.
module tb_flash_test_seq;
  import flash_test_pkg::*;

  localparam logic [23:0] BASE   = 24'h1a0000;
  localparam int          LENI   = 16;
  localparam logic [7:0]  SEED_V = 8'h00;
  localparam int          TO     = 100;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_cnt;
  logic [23:0] first_err_addr;
  logic        flash_sector_erase, flash_write, flash_read;
  logic        flash_sector_erase_ack = 1'b0;
  logic        flash_write_ack = 1'b0;
  logic        flash_read_ack = 1'b0;
  logic [23:0] flash_addr;
  logic [7:0]  flash_size;
  logic        flash_write_data_req = 1'b0;
  logic [7:0]  flash_write_data_in;
  logic        flash_read_data_valid = 1'b0;
  logic [7:0]  flash_read_data_out = 8'h00;

  always #5 sys_clk = ~sys_clk;

  flash_test_seq #(
    .BASE_ADDR (BASE),
    .LEN       (8'(LENI)),
    .SEED      (SEED_V),
    .TIMEOUT   (28'(TO))
  ) dut (
    .sys_clk                (sys_clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .busy                   (busy),
    .done                   (done),
    .pass                   (pass),
    .timeout                (timeout),
    .err_cnt                (err_cnt),
    .first_err_addr         (first_err_addr),
    .flash_sector_erase     (flash_sector_erase),
    .flash_write            (flash_write),
    .flash_read             (flash_read),
    .flash_sector_erase_ack (flash_sector_erase_ack),
    .flash_write_ack        (flash_write_ack),
    .flash_read_ack         (flash_read_ack),
    .flash_addr             (flash_addr),
    .flash_size             (flash_size),
    .flash_write_data_req   (flash_write_data_req),
    .flash_write_data_in    (flash_write_data_in),
    .flash_read_data_valid  (flash_read_data_valid),
    .flash_read_data_out    (flash_read_data_out)
  );

  typedef struct {
    logic        pass;
    logic        to;
    logic [7:0]  err;
    logic [23:0] first;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] byte_q[$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Request monitor: overlap, rising edges and erase high-time
  int   n_multi = 0, n_er_rise = 0, n_wr_rise = 0, n_rd_rise = 0, erase_hi = 0;
  logic pe = 1'b0, pw = 1'b0, pr = 1'b0;
  always @(negedge sys_clk) begin
    if (int'(flash_sector_erase) + int'(flash_write) + int'(flash_read) > 1) n_multi++;
    if (flash_sector_erase && !pe) n_er_rise++;
    if (flash_write && !pw) n_wr_rise++;
    if (flash_read && !pr) n_rd_rise++;
    if (flash_sector_erase) erase_hi++;
    pe = flash_sector_erase;
    pw = flash_write;
    pr = flash_read;
  end

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return flash_sector_erase;
      1:       return flash_write;
      2:       return flash_read;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, input string tag, output bit ok);
    int n = 0;
    while (!get_sig(sel) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    ok = get_sig(sel);
    if (!ok) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic do_start();
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic do_erase(output bit ok);
    wait_sig(0, 20, "wait_erase", ok);
    if (!ok) return;
    flash_sector_erase_ack = 1'b1;
    @(negedge sys_clk) flash_sector_erase_ack = 1'b0;
  endtask

  task automatic do_write(input int extra, input bit start_mid, output bit ok);
    logic [7:0] cap;
    logic [7:0] b;
    for (int i = 0; i < LENI; i++) byte_q.push_back(SEED_V + 8'(i));
    wait_sig(1, 20, "wait_write", ok);
    if (!ok) return;
    for (int i = 0; i < LENI + extra; i++) begin
      @(negedge sys_clk);
      cap = flash_write_data_in;
      flash_write_data_req = 1'b1;
      if (start_mid && i == 3) start = 1'b1;
      @(negedge sys_clk);
      flash_write_data_req = 1'b0;
      start = 1'b0;
      if (i < LENI) begin
        b = byte_q.pop_front();
        chk("wr_byte", cap, b);
      end else begin
        chk("wr_hold", cap, SEED_V + 8'(LENI - 1));
      end
    end
    @(negedge sys_clk) flash_write_ack = 1'b1;
    @(negedge sys_clk) flash_write_ack = 1'b0;
  endtask

  task automatic send_valid(input logic [7:0] d);
    @(negedge sys_clk);
    flash_read_data_valid = 1'b1;
    flash_read_data_out = d;
    @(negedge sys_clk) flash_read_data_valid = 1'b0;
  endtask

  task automatic run_case(input string tag, input int corrupt, input int n_valid, input int extra,
                          input bit hold_erase, input bit start_mid);
    res_t e;
    res_t g;
    int   err;
    int   er0, wr0, rd0, eh0;
    bit   ok;
    err = 0;
    for (int i = 0; i < n_valid && i < LENI; i++) if (i == corrupt) err++;
    if (n_valid < LENI) err += LENI - n_valid;
    e.first = (corrupt >= 0 && corrupt < n_valid && corrupt < LENI) ? BASE + 24'(corrupt) : 24'h0;
    if (hold_erase) begin
      err = 0;
      e.first = 24'h0;
    end
    e.err  = (err > 255) ? 8'hFF : 8'(err);
    e.to   = hold_erase;
    e.pass = (err == 0) && !hold_erase;
    exp_q.push_back(e);
    er0 = n_er_rise; wr0 = n_wr_rise; rd0 = n_rd_rise; eh0 = erase_hi;
    do_start();
    if (hold_erase) begin
      wait_sig(0, 20, "wait_erase", ok);
      if (!ok) return;
    end else begin
      do_erase(ok);
      if (!ok) return;
      do_write(extra, start_mid, ok);
      if (!ok) return;
      wait_sig(2, 20, "wait_read", ok);
      if (!ok) return;
      for (int i = 0; i < n_valid + extra; i++) begin
        if (i == corrupt) send_valid(8'hFF);
        else if (i < LENI) send_valid(SEED_V + 8'(i));
        else send_valid(8'h5A);
      end
      @(negedge sys_clk) flash_read_ack = 1'b1;
      @(negedge sys_clk) flash_read_ack = 1'b0;
    end
    wait_sig(3, 3 * TO, {tag, "_wait_done"}, ok);
    if (!ok) return;
    g = exp_q.pop_front();
    chk({tag, "_pass"}, pass, g.pass);
    chk({tag, "_timeout"}, timeout, g.to);
    chk({tag, "_err_cnt"}, err_cnt, g.err);
    chk({tag, "_first_err"}, first_err_addr, g.first);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_erase_rises"}, n_er_rise - er0, 1);
    chk({tag, "_write_rises"}, n_wr_rise - wr0, hold_erase ? 0 : 1);
    chk({tag, "_read_rises"}, n_rd_rise - rd0, hold_erase ? 0 : 1);
    if (hold_erase) begin
      chk({tag, "_erase_dropped"}, flash_sector_erase, 1'b0);
      chk({tag, "_erase_hi_window"}, ((erase_hi - eh0) >= TO - 1) && ((erase_hi - eh0) <= TO), 1'b1);
    end
    @(negedge sys_clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_pass_hold"}, pass, g.pass);
    if (start_mid) begin
      repeat (5) @(negedge sys_clk);
      chk({tag, "_no_rerun"}, n_er_rise - er0, 1);
      chk({tag, "_idle_busy"}, busy, 1'b0);
    end
  endtask

  task automatic reset_in_read();
    bit ok;
    do_start();
    do_erase(ok);
    if (!ok) return;
    do_write(0, 1'b0, ok);
    if (!ok) return;
    wait_sig(2, 20, "rst_wait_read", ok);
    if (!ok) return;
    send_valid(8'hFF);
    send_valid(8'hFF);
    chk("rst_pre_err", err_cnt, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_read_low", flash_read, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_first_err", first_err_addr, 24'h0);
    @(negedge sys_clk) rst_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_busy0", busy, 1'b0);
    chk("rst_done0", done, 1'b0);
    chk("rst_pass0", pass, 1'b0);
    chk("rst_timeout0", timeout, 1'b0);
    chk("rst_err0", err_cnt, 8'd0);
    chk("rst_first0", first_err_addr, 24'h0);
    chk("rst_reqs0", {flash_sector_erase, flash_write, flash_read}, 3'b000);
    chk("rst_wdata0", flash_write_data_in, SEED_V);
    chk("flash_addr", flash_addr, BASE);
    chk("flash_size", flash_size, 8'(LENI));
    @(negedge sys_clk) rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    run_case("good",     -1, LENI, 0, 1'b0, 1'b0);
    run_case("extras",   -1, LENI, 2, 1'b0, 1'b0);
    run_case("corrupt5",  5, LENI, 0, 1'b0, 1'b0);
    run_case("short10",  -1, 10,   0, 1'b0, 1'b0);
    run_case("erase_to", -1, LENI, 0, 1'b1, 1'b0);
    run_case("start_mid",-1, LENI, 0, 1'b0, 1'b1);
    reset_in_read();
    repeat (2) @(negedge sys_clk);
    run_case("after_rst",-1, LENI, 0, 1'b0, 1'b0);

    chk("one_req_at_a_time", n_multi, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule
